// File: rtl/cv32e41s_rvfi_mem_tracker_pkg.sv
// Types shared by the RVFI data-side memory tracker: OBI request payload, block reasons, trace record.
// Pure type/constant package; no logic, no latency, no flow control.
// Record seq field is fixed at 16 bits; narrower tags are zero-extended, wider ones truncated.
package cv32e41s_rvfi_mem_tracker_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  prot;
    } obi_data_req_t;

    typedef enum logic [1:0] {
        MEM_ERR_IO_ALIGN = 2'd0,
        MEM_ERR_ATOMIC   = 2'd1,
        MEM_ERR_PMP      = 2'd2
    } mem_err_t;

    typedef struct packed {
        obi_data_req_t req;
        logic [31:0]   rdata;
        logic          bus_err;
        logic          blocked;
        mem_err_t      err_type;
        logic [15:0]   seq;
    } rvfi_mem_rec_t;

endpackage

// File: rtl/cv32e41s_rvfi_mem_tracker_scan.sv
// Finds the oldest live, incomplete queue entry by priority scan starting at rd_ptr.
// Purely combinational, zero latency.
// No flow control; found=0 when every live entry is already complete.
module cv32e41s_rvfi_mem_tracker_scan #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0] complete,
    input  logic [PW-1:0]    rd_ptr,
    input  logic [CW-1:0]    count,
    output logic             found,
    output logic [PW-1:0]    idx
);

    // Walk from youngest to oldest so the last hit (closest to rd_ptr) wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < count) && !complete[rd_ptr + PW'(i)]) begin
                found = 1'b1;
                idx   = rd_ptr + PW'(i);
            end
        end
    end

endmodule

// File: rtl/cv32e41s_rvfi_mem_tracker.sv
// In-order tracker pairing data-side OBI requests with responses/block outcomes into RVFI memory records.
// Latency: a record is presented the cycle after its completing push or response; outputs depend on state only.
// Backpressure: head is held while out_ready_i=0; pushes while full are dropped and flagged (overflow_o).
// Optional response timeout enabled by defining CV32E41S_RVFI_MEM_TRACKER_TIMEOUT_EN.
module cv32e41s_rvfi_mem_tracker
    import cv32e41s_rvfi_mem_tracker_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int SEQ_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    input  obi_data_req_t              req_payload_i,
    input  logic                       req_blocked_i,
    input  mem_err_t                   req_err_type_i,
    input  logic                       rsp_valid_i,
    input  logic [31:0]                rsp_rdata_i,
    input  logic                       rsp_err_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output rvfi_mem_rec_t              out_record_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    output logic                       timeout_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, outstanding;
    logic [SEQ_W-1:0] seq_cnt;
    logic [DEPTH-1:0] cplt;
    logic             overflow_q, underflow_q;

    obi_data_req_t    req_mem   [DEPTH];
    logic [SEQ_W-1:0] seq_mem   [DEPTH];
    mem_err_t         err_mem   [DEPTH];
    logic [31:0]      rdata_mem [DEPTH];
    logic [DEPTH-1:0] blk_mem, berr_mem;

    logic          full, empty, push, push_bus, pop, rsp_ok, tgt_found;
    logic [PW-1:0] tgt_idx;

    cv32e41s_rvfi_mem_tracker_scan #(.DEPTH(DEPTH)) u_scan (
        .complete (cplt),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .found    (tgt_found),
        .idx      (tgt_idx)
    );

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = req_valid_i & ~full;
    assign push_bus = push & ~req_blocked_i;
    // An entry pushed this cycle is outside count, so it can never be the response target.
    assign rsp_ok   = rsp_valid_i & tgt_found & (outstanding != '0);
    assign pop      = out_valid_o & out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            seq_cnt     <= '0;
            cplt        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(push);
            rd_ptr      <= rd_ptr + PW'(pop);
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(push_bus) - CW'(rsp_ok);
            seq_cnt     <= seq_cnt + SEQ_W'(push);
            if (push)
                cplt[wr_ptr] <= req_blocked_i;
            if (rsp_ok)
                cplt[tgt_idx] <= 1'b1;
            if (req_valid_i && full)
                overflow_q <= 1'b1;
            if (rsp_valid_i && !rsp_ok)
                underflow_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: it is only observed through complete, live entries.
    always_ff @(posedge clk) begin
        if (push) begin
            req_mem[wr_ptr]   <= req_payload_i;
            seq_mem[wr_ptr]   <= seq_cnt;
            blk_mem[wr_ptr]   <= req_blocked_i;
            err_mem[wr_ptr]   <= req_blocked_i ? req_err_type_i : MEM_ERR_IO_ALIGN;
            rdata_mem[wr_ptr] <= '0;
            berr_mem[wr_ptr]  <= 1'b0;
        end
        if (rsp_ok) begin
            rdata_mem[tgt_idx] <= rsp_rdata_i;
            berr_mem[tgt_idx]  <= rsp_err_i;
        end
    end

    assign out_valid_o = ~empty & cplt[rd_ptr];

    always_comb begin
        out_record_o = '0;
        if (out_valid_o) begin
            out_record_o.req      = req_mem[rd_ptr];
            out_record_o.rdata    = rdata_mem[rd_ptr];
            out_record_o.bus_err  = berr_mem[rd_ptr];
            out_record_o.blocked  = blk_mem[rd_ptr];
            out_record_o.err_type = err_mem[rd_ptr];
            out_record_o.seq      = 16'(seq_mem[rd_ptr]);
        end
    end

    assign full_o        = full;
    assign empty_o       = empty;
    assign outstanding_o = outstanding;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;

`ifdef CV32E41S_RVFI_MEM_TRACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          timeout_q;

    // Counter saturates at the limit so the flag condition stays stable while stalled.
    always_comb begin
        tmo_nxt = tmo_cnt;
        if (rsp_valid_i || (outstanding == '0))
            tmo_nxt = '0;
        else if (tmo_cnt != TW'(TIMEOUT_CYCLES))
            tmo_nxt = tmo_cnt + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt <= tmo_nxt;
            if (tmo_nxt == TW'(TIMEOUT_CYCLES))
                timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e41s_rvfi_mem_tracker.sv
// Self-checking bench for cv32e41s_rvfi_mem_tracker: directed scenarios plus randomized traffic vs a queue model.
module tb_cv32e41s_rvfi_mem_tracker;
    import cv32e41s_rvfi_mem_tracker_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid;
    obi_data_req_t req_payload;
    logic          req_blocked;
    mem_err_t      req_err_type;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          out_valid;
    logic          out_ready;
    rvfi_mem_rec_t out_record;
    logic          full, empty, overflow, underflow, timeout;
    logic [2:0]    outstanding;

    always #5 clk = ~clk;

    cv32e41s_rvfi_mem_tracker #(.DEPTH(DEPTH), .SEQ_W(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_payload_i  (req_payload),
        .req_blocked_i  (req_blocked),
        .req_err_type_i (req_err_type),
        .rsp_valid_i    (rsp_valid),
        .rsp_rdata_i    (rsp_rdata),
        .rsp_err_i      (rsp_err),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_record_o   (out_record),
        .full_o         (full),
        .empty_o        (empty),
        .outstanding_o  (outstanding),
        .overflow_o     (overflow),
        .underflow_o    (underflow),
        .timeout_o      (timeout)
    );

    typedef struct {
        rvfi_mem_rec_t rec;
        bit            done;
    } ent_t;

    ent_t          mq[$];
    rvfi_mem_rec_t pops[$];
    int            m_seq, m_out, m_tcnt;
    bit            m_ovf, m_unf, m_tmo;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic obi_data_req_t rand_payload();
        obi_data_req_t p;
        p.addr  = $urandom;
        p.we    = 1'($urandom);
        p.be    = 4'($urandom);
        p.wdata = $urandom;
        p.prot  = 3'($urandom);
        return p;
    endfunction

    task automatic idle();
        req_valid    = 1'b0;
        req_payload  = '0;
        req_blocked  = 1'b0;
        req_err_type = MEM_ERR_IO_ALIGN;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_err      = 1'b0;
        out_ready    = 1'b0;
    endtask

    task automatic set_req(input bit blk, input mem_err_t e);
        req_valid    = 1'b1;
        req_payload  = rand_payload();
        req_blocked  = blk;
        req_err_type = e;
    endtask

    // Reference behaviour: ordered list of records; a response completes the first unfinished one.
    task automatic model_step();
        int   pre;
        bit   do_pop;
        ent_t e;
        pre    = mq.size();
        do_pop = (pre > 0) && mq[0].done && out_ready;
`ifdef CV32E41S_RVFI_MEM_TRACKER_TIMEOUT_EN
        if (rsp_valid || m_out == 0) m_tcnt = 0;
        else if (m_tcnt < TMO) m_tcnt++;
        if (m_tcnt == TMO) m_tmo = 1'b1;
`endif
        if (rsp_valid) begin
            if (m_out == 0) m_unf = 1'b1;
            else begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].done) begin
                        e = mq[i];
                        e.done = 1'b1;
                        e.rec.rdata = rsp_rdata;
                        e.rec.bus_err = rsp_err;
                        mq[i] = e;
                        m_out--;
                        break;
                    end
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (req_valid) begin
            if (pre == DEPTH) m_ovf = 1'b1;
            else begin
                e.rec          = '0;
                e.rec.req      = req_payload;
                e.rec.seq      = 16'(m_seq);
                e.rec.blocked  = req_blocked;
                e.rec.err_type = req_blocked ? req_err_type : MEM_ERR_IO_ALIGN;
                e.done         = req_blocked;
                mq.push_back(e);
                m_seq = (m_seq + 1) % 65536;
                if (!req_blocked) m_out++;
            end
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (mq.size() > 0) && mq[0].done;
        check("out_valid", out_valid, ev);
        check("empty", empty, mq.size() == 0);
        check("full", full, mq.size() == DEPTH);
        check("outstanding", outstanding, m_out);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_unf);
        check("timeout", timeout, m_tmo);
        if (ev && out_valid) check("record", out_record, mq[0].rec);
    endtask

    // Inputs are set at a negedge; one call advances one clock and re-checks at the next negedge.
    task automatic tick();
        if (out_valid && out_ready) pops.push_back(out_record);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        pops.delete();
        m_seq = 0; m_out = 0; m_tcnt = 0;
        m_ovf = 1'b0; m_unf = 1'b0; m_tmo = 1'b0;
        check_outputs();
        check("rst_record", out_record, '0);
    endtask

    task automatic drain(input int n);
        repeat (n) begin out_ready = 1'b1; tick(); end
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();

        // Response with nothing outstanding.
        rsp_valid = 1'b1; rsp_rdata = 32'h5; tick();
        check("unf_flag", underflow, 1'b1);
        check("unf_empty", empty, 1'b1);
        check("unf_valid", out_valid, 1'b0);

        // Three reads, responses A/B/C, visible one cycle after each response.
        do_reset();
        repeat (3) begin set_req(1'b0, MEM_ERR_IO_ALIGN); tick(); end
        for (int i = 0; i < 3; i++) begin
            rsp_valid = 1'b1; rsp_rdata = 32'hA + i; out_ready = 1'b1; tick();
            check("t1_vld_after_rsp", out_valid, 1'b1);
        end
        drain(2);
        check("t1_pops", pops.size(), 3);
        for (int i = 0; i < 3 && i < pops.size(); i++) begin
            check("t1_seq", pops[i].seq, i);
            check("t1_rdata", pops[i].rdata, 32'hA + i);
        end

        // Read, PMP-blocked write, read: blocked record waits behind the first read.
        do_reset();
        set_req(1'b0, MEM_ERR_IO_ALIGN); out_ready = 1'b1; tick();
        set_req(1'b1, MEM_ERR_PMP); out_ready = 1'b1; tick();
        set_req(1'b0, MEM_ERR_IO_ALIGN); out_ready = 1'b1; tick();
        check("t2_blk_held", out_valid, 1'b0);
        rsp_valid = 1'b1; rsp_rdata = 32'h11; out_ready = 1'b1; tick();
        rsp_valid = 1'b1; rsp_rdata = 32'h22; out_ready = 1'b1; tick();
        drain(3);
        check("t2_pops", pops.size(), 3);
        if (pops.size() == 3) begin
            check("t2_rd0", pops[0].rdata, 32'h11);
            check("t2_blk", pops[1].blocked, 1'b1);
            check("t2_pmp", pops[1].err_type, MEM_ERR_PMP);
            check("t2_blk_rdata", pops[1].rdata, 0);
            check("t2_rd1", pops[2].rdata, 32'h22);
            check("t2_seq2", pops[2].seq, 2);
        end

        // Five pushes into a 4-deep queue with the consumer stalled.
        do_reset();
        repeat (5) begin set_req(1'b1, MEM_ERR_ATOMIC); tick(); end
        check("t3_full", full, 1'b1);
        check("t3_ovf", overflow, 1'b1);
        drain(5);
        set_req(1'b1, MEM_ERR_ATOMIC); tick();
        drain(2);
        check("t3_pops", pops.size(), 5);
        for (int i = 0; i < 5 && i < pops.size(); i++) check("t3_seq", pops[i].seq, i);

        // Push + response + pop in one cycle with two live entries.
        do_reset();
        set_req(1'b1, MEM_ERR_PMP); tick();
        set_req(1'b0, MEM_ERR_IO_ALIGN); tick();
        check("t5_out_before", outstanding, 1);
        set_req(1'b0, MEM_ERR_IO_ALIGN); rsp_valid = 1'b1; rsp_rdata = 32'h55; out_ready = 1'b1; tick();
        check("t5_out_after", outstanding, 1);
        check("t5_pop", pops.size(), 1);
        check("t5_empty", empty, 1'b0);
        rsp_valid = 1'b1; rsp_rdata = 32'h66; out_ready = 1'b1; tick();
        drain(3);
        check("t5_pops", pops.size(), 3);

        // Reset with reads in flight, then sequence restarts at 0.
        do_reset();
        repeat (3) begin set_req(1'b0, MEM_ERR_IO_ALIGN); tick(); end
        check("t6_out", outstanding, 3);
        do_reset();
        set_req(1'b1, MEM_ERR_ATOMIC); tick();
        drain(1);
        check("t6_pops", pops.size(), 1);
        if (pops.size() == 1) check("t6_seq", pops[0].seq, 0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 99) < 40)
                set_req($urandom_range(0, 99) < 25, mem_err_t'($urandom_range(0, 2)));
            if (m_out > 0) rsp_valid = ($urandom_range(0, 99) < 45);
            else           rsp_valid = ($urandom_range(0, 199) == 0);
            rsp_rdata = $urandom;
            rsp_err   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 99) < 60);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
